// File: rtl/ysyx_22050499_wb_commit.sv
// Write-back/commit stage: holds one instruction from MEM, selects the writeback value,
// drives the GPR/CSR write ports, pulses retire and counts retired instructions.
module ysyx_22050499_wb_commit #(
    parameter int unsigned BUS_W = 179,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wb_in_valid,
    input  logic [BUS_W-1:0] wb_in_bits,
    output logic             wb_in_ready,
    input  logic             commit_hold,
    output logic [31:0]      wb_pc,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             csr_we,
    output logic [2:0]       csr_waddr,
    output logic [31:0]      csr_wdata,
    output logic             retire_valid,
    output logic [31:0]      retire_pc,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] load_data;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] csr_val;
        logic [1:0]  mem_to_reg;
        logic [2:0]  csr_addr;
        logic [4:0]  rd;
        logic        csr_we;
        logic        gpr_we;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           entry_q, entry_d;
    entry_t           entry_in;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             accept;
    logic             commit;
    logic             gpr_write;
    logic [31:0]      wb_value;

    // Bits [82:44] of the MEM bus carry fields this stage does not consume.
    logic             unused_bus_bits;
    assign unused_bus_bits = ^wb_in_bits[82:44];

    always_comb begin
        entry_in            = '0;
        entry_in.load_data  = wb_in_bits[178:147];
        entry_in.pc         = wb_in_bits[146:115];
        entry_in.alu        = wb_in_bits[114:83];
        entry_in.csr_val    = wb_in_bits[43:12];
        entry_in.mem_to_reg = wb_in_bits[11:10];
        entry_in.csr_addr   = wb_in_bits[9:7];
        entry_in.rd         = wb_in_bits[6:2];
        entry_in.csr_we     = wb_in_bits[1];
        entry_in.gpr_we     = wb_in_bits[0];
    end

    assign wb_in_ready = (state_q == IDLE) | ((state_q == COMMIT) & ~commit_hold);
    assign accept      = wb_in_valid & wb_in_ready;
    assign commit      = (state_q == COMMIT) & ~commit_hold & ~reset;
    assign gpr_write   = entry_q.gpr_we & (entry_q.rd != 5'd0);

    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        instret_d = instret_q;
        if (accept) begin
            state_d = COMMIT;
            entry_d = entry_in;
        end else if ((state_q == COMMIT) && !commit_hold) begin
            state_d = IDLE;
        end
        if (commit) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            entry_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        wb_value = entry_q.alu;
        unique case (entry_q.mem_to_reg)
            2'b00: wb_value = entry_q.alu;
            2'b01: wb_value = entry_q.load_data;
            2'b10: wb_value = entry_q.csr_val;
            2'b11: wb_value = entry_q.pc + 32'd4;
            default: wb_value = entry_q.alu;
        endcase
    end

    // Entry is not cleared on leaving COMMIT, so wb_pc keeps the last committed pc.
    assign wb_pc        = entry_q.pc;
    assign rf_we        = commit & gpr_write;
    assign rf_waddr     = entry_q.rd;
    assign rf_wdata     = wb_value;
    assign csr_we       = commit & entry_q.csr_we;
    assign csr_waddr    = entry_q.csr_addr;
    assign csr_wdata    = entry_q.alu;
    assign retire_valid = commit;
    assign retire_pc    = entry_q.pc;
    assign fwd_valid    = (state_q == COMMIT) & gpr_write & ~reset;
    assign fwd_rd       = entry_q.rd;
    assign fwd_data     = wb_value;
    assign instret      = instret_q;

endmodule

// File: tb/tb_ysyx_22050499_wb_commit.sv
// Directed bench for the write-back/commit stage; expected values are hand-computed.
module tb_ysyx_22050499_wb_commit;

    logic         clock;
    logic         reset;
    logic         wb_in_valid;
    logic [178:0] wb_in_bits;
    logic         wb_in_ready;
    logic         commit_hold;
    logic [31:0]  wb_pc;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         csr_we;
    logic [2:0]   csr_waddr;
    logic [31:0]  csr_wdata;
    logic         retire_valid;
    logic [31:0]  retire_pc;
    logic         fwd_valid;
    logic [4:0]   fwd_rd;
    logic [31:0]  fwd_data;
    logic [63:0]  instret;

    int checks   = 0;
    int failures = 0;

    ysyx_22050499_wb_commit #(.BUS_W(179), .CNT_W(64)) dut (
        .clock       (clock),
        .reset       (reset),
        .wb_in_valid (wb_in_valid),
        .wb_in_bits  (wb_in_bits),
        .wb_in_ready (wb_in_ready),
        .commit_hold (commit_hold),
        .wb_pc       (wb_pc),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .csr_we      (csr_we),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .retire_valid(retire_valid),
        .retire_pc   (retire_pc),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .instret     (instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [178:0] mk(input logic [31:0] ld, input logic [31:0] pc,
                                        input logic [31:0] alu, input logic [31:0] csrv,
                                        input logic [1:0] m2r, input logic [2:0] caddr,
                                        input logic [4:0] rd, input logic cwe, input logic gwe);
        logic [178:0] b;
        b          = '0;
        b[178:147] = ld;
        b[146:115] = pc;
        b[114:83]  = alu;
        b[82:44]   = 39'h5A_5A5A_5A5A;
        b[43:12]   = csrv;
        b[11:10]   = m2r;
        b[9:7]     = caddr;
        b[6:2]     = rd;
        b[1]       = cwe;
        b[0]       = gwe;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        wb_in_valid = 1'b0;
        wb_in_bits  = '0;
        commit_hold = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_ready",   64'(wb_in_ready), 64'd1);
        chk("rst_rf_we",   64'(rf_we), 64'd0);
        chk("rst_retire",  64'(retire_valid), 64'd0);
        chk("rst_fwd",     64'(fwd_valid), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_wb_pc",   64'(wb_pc), 64'd0);

        // ALU result write
        wb_in_bits  = mk(32'h0, 32'h8000_0000, 32'h12, 32'h0, 2'b00, 3'd0, 5'd5, 1'b0, 1'b1);
        wb_in_valid = 1'b1;
        step();
        wb_in_valid = 1'b0;
        chk("alu_rf_we",     64'(rf_we), 64'd1);
        chk("alu_waddr",     64'(rf_waddr), 64'd5);
        chk("alu_wdata",     64'(rf_wdata), 64'h12);
        chk("alu_retire",    64'(retire_valid), 64'd1);
        chk("alu_retire_pc", 64'(retire_pc), 64'h8000_0000);
        chk("alu_csr_we",    64'(csr_we), 64'd0);
        chk("alu_fwd_valid", 64'(fwd_valid), 64'd1);
        chk("alu_fwd_rd",    64'(fwd_rd), 64'd5);
        chk("alu_fwd_data",  64'(fwd_data), 64'h12);
        step();
        chk("alu_instret",   instret, 64'd1);
        chk("idle_retire",   64'(retire_valid), 64'd0);
        chk("idle_rf_we",    64'(rf_we), 64'd0);
        chk("idle_wb_pc",    64'(wb_pc), 64'h8000_0000);

        // Load then jal back-to-back
        wb_in_bits  = mk(32'hFFFF_FF80, 32'h8000_0004, 32'hDEAD, 32'h0, 2'b01, 3'd0, 5'd3, 1'b0, 1'b1);
        wb_in_valid = 1'b1;
        step();
        chk("ld_wdata",   64'(rf_wdata), 64'hFFFF_FF80);
        chk("ld_waddr",   64'(rf_waddr), 64'd3);
        chk("ld_rf_we",   64'(rf_we), 64'd1);
        chk("ld_ready",   64'(wb_in_ready), 64'd1);
        wb_in_bits = mk(32'h0, 32'h8000_0010, 32'h5, 32'h0, 2'b11, 3'd0, 5'd1, 1'b0, 1'b1);
        step();
        wb_in_valid = 1'b0;
        chk("jal_wdata",   64'(rf_wdata), 64'h8000_0014);
        chk("jal_waddr",   64'(rf_waddr), 64'd1);
        chk("jal_retire",  64'(retire_valid), 64'd1);
        chk("jal_instret", instret, 64'd2);
        step();
        chk("b2b_instret", instret, 64'd3);

        // CSR write
        wb_in_bits  = mk(32'h0, 32'h8000_0020, 32'h1800, 32'h8, 2'b10, 3'd2, 5'd7, 1'b1, 1'b1);
        wb_in_valid = 1'b1;
        step();
        wb_in_valid = 1'b0;
        chk("csr_we",    64'(csr_we), 64'd1);
        chk("csr_waddr", 64'(csr_waddr), 64'd2);
        chk("csr_wdata", 64'(csr_wdata), 64'h1800);
        chk("csr_rf",    64'(rf_wdata), 64'h8);
        step();
        chk("csr_instret", instret, 64'd4);
        chk("csr_we_idle", 64'(csr_we), 64'd0);

        // rd == 0
        wb_in_bits  = mk(32'h0, 32'h8000_0024, 32'h99, 32'h0, 2'b00, 3'd0, 5'd0, 1'b0, 1'b1);
        wb_in_valid = 1'b1;
        step();
        wb_in_valid = 1'b0;
        chk("x0_rf_we",  64'(rf_we), 64'd0);
        chk("x0_fwd",    64'(fwd_valid), 64'd0);
        chk("x0_retire", 64'(retire_valid), 64'd1);
        step();
        chk("x0_instret", instret, 64'd5);

        // Hold for three cycles in COMMIT
        wb_in_bits  = mk(32'h0, 32'h8000_0028, 32'h77, 32'h0, 2'b00, 3'd0, 5'd9, 1'b0, 1'b1);
        wb_in_valid = 1'b1;
        step();
        wb_in_valid = 1'b0;
        commit_hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_ready",   64'(wb_in_ready), 64'd0);
            chk("hold_retire",  64'(retire_valid), 64'd0);
            chk("hold_rf_we",   64'(rf_we), 64'd0);
            chk("hold_fwd",     64'(fwd_valid), 64'd1);
            chk("hold_instret", instret, 64'd5);
            if (i < 2) step();
        end
        commit_hold = 1'b0;
        #1;
        chk("rel_retire", 64'(retire_valid), 64'd1);
        chk("rel_wdata",  64'(rf_wdata), 64'h77);
        chk("rel_waddr",  64'(rf_waddr), 64'd9);
        step();
        chk("rel_instret", instret, 64'd6);
        chk("rel_retire_off", 64'(retire_valid), 64'd0);

        // pc+4 wrap, then reset while in COMMIT
        wb_in_bits  = mk(32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'b11, 3'd0, 5'd4, 1'b0, 1'b1);
        wb_in_valid = 1'b1;
        step();
        wb_in_valid = 1'b0;
        chk("wrap_wdata", 64'(rf_wdata), 64'd0);
        chk("wrap_rf_we", 64'(rf_we), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstc_rf_we",  64'(rf_we), 64'd0);
        chk("rstc_retire", 64'(retire_valid), 64'd0);
        chk("rstc_fwd",    64'(fwd_valid), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rstc_ready",   64'(wb_in_ready), 64'd1);
        chk("rstc_instret", instret, 64'd0);
        chk("rstc_wb_pc",   64'(wb_pc), 64'd0);
        step();
        chk("rstc_idle_we", 64'(rf_we), 64'd0);
        chk("rstc_idle_rt", 64'(retire_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
